dout_wled_rgb: RTL and testbench

- Parametrised successor to the single-bit WS2812 digital-output driver.
- Drives a chain of NUM_LEDS WS2812-compatible LEDs from per-LED multi-bit colour inputs, with a global brightness scale.
- Contains its own bit-timing generator and latch (reset) gap; frames run continuously or on request.
- Sits between the RIO register interface (colour/brightness registers) and one FPGA output pin.

---
 rtl/wled_pkg.sv | 42 ++++
 rtl/wled_bit_tx.sv | 63 ++++++
 rtl/dout_wled_rgb.sv | 120 ++++++++++++
 tb/tb_dout_wled_rgb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wled_pkg.sv
// Shared types and helpers for the WS2812 chain driver: FSM states, cycle-count
// derivation from nanosecond timings, and colour-depth expansion.
package wled_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BIT,
        LATCH
    } wled_state_t;

    localparam int WORD_BITS = 24;

    function automatic int c0h_cycles(input int clk_mhz, input int t0h_ns);
        return clk_mhz * t0h_ns / 1000;
    endfunction

    function automatic int c1h_cycles(input int clk_mhz, input int t1h_ns);
        return clk_mhz * t1h_ns / 1000;
    endfunction

    function automatic int cbit_cycles(input int clk_mhz, input int tbit_ns);
        return clk_mhz * tbit_ns / 1000;
    endfunction

    function automatic int crst_cycles(input int clk_mhz, input int reset_us);
        return clk_mhz * reset_us;
    endfunction

    // Widen a 'bits'-wide intensity to 8 bits by repeating its pattern from the MSB down.
    function automatic logic [7:0] expand_color(input logic [7:0] c, input int bits);
        logic [7:0] res;
        logic [2:0] k;
        res = '0;
        for (int j = 0; j < 8; j++) begin
            k   = 3'(bits - 1 - (j % bits));
            res = {res[6:0], c[k]};
        end
        return res;
    endfunction

endpackage

// File: rtl/wled_bit_tx.sv
// Serialises one 24-bit GRB word MSB first as WS2812 pulses; 'ready' marks the
// final cycle of the last bit so the caller can load the next word or latch.
module wled_bit_tx
    import wled_pkg::*;
#(
    parameter int C0H  = 10,
    parameter int C1H  = 21,
    parameter int CBIT = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WORD_BITS-1:0] word,
    output logic                 wled,
    output logic                 ready
);

    localparam int CW = (CBIT > 2) ? $clog2(CBIT) : 1;
    localparam int IW = $clog2(WORD_BITS);

    logic [WORD_BITS-1:0] shreg;
    logic [IW-1:0]        bit_idx;
    logic [CW-1:0]        cnt;
    logic                 active;
    logic [CW-1:0]        th_cur;
    logic                 high_next;

    assign th_cur    = shreg[bit_idx] ? CW'(C1H) : CW'(C0H);
    assign high_next = shreg[bit_idx - IW'(1)] ? (C1H > 0) : (C0H > 0);
    assign ready     = active && (cnt == CW'(CBIT - 1)) && (bit_idx == '0);

    // wled is computed one cycle ahead from the next counter value so the pin is driven by a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            active  <= 1'b0;
            wled    <= 1'b0;
        end else if (load) begin
            shreg   <= word;
            bit_idx <= IW'(WORD_BITS - 1);
            cnt     <= '0;
            active  <= 1'b1;
            wled    <= word[WORD_BITS-1] ? (C1H > 0) : (C0H > 0);
        end else if (active) begin
            if (cnt == CW'(CBIT - 1)) begin
                cnt <= '0;
                if (bit_idx == '0) begin
                    active <= 1'b0;
                    wled   <= 1'b0;
                end else begin
                    bit_idx <= bit_idx - IW'(1);
                    wled    <= high_next;
                end
            end else begin
                cnt  <= cnt + CW'(1);
                wled <= (cnt + CW'(1)) < th_cur;
            end
        end
    end

endmodule

// File: rtl/dout_wled_rgb.sv
// WS2812 chain driver: walks NUM_LEDS colour inputs, scales by global brightness,
// feeds the bit serialiser and inserts the latch gap between frames.
module dout_wled_rgb
    import wled_pkg::*;
#(
    parameter int CLK_MHZ      = 27,
    parameter int NUM_LEDS     = 1,
    parameter int COLOR_BITS   = 1,
    parameter int AUTO_REFRESH = 1,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 800,
    parameter int TBIT_NS      = 1250,
    parameter int RESET_US     = 300
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_LEDS*COLOR_BITS-1:0] green,
    input  logic [NUM_LEDS*COLOR_BITS-1:0] red,
    input  logic [NUM_LEDS*COLOR_BITS-1:0] blue,
    input  logic [7:0]                     bright,
    input  logic                           start,
    output logic                           wled,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int C0H  = c0h_cycles(CLK_MHZ, T0H_NS);
    localparam int C1H  = c1h_cycles(CLK_MHZ, T1H_NS);
    localparam int CBIT = cbit_cycles(CLK_MHZ, TBIT_NS);
    localparam int CRST = crst_cycles(CLK_MHZ, RESET_US);
    localparam int RW   = $clog2(CRST);

    wled_state_t            state;
    logic [7:0]             idx;
    logic [RW-1:0]          rst_cnt;
    logic [COLOR_BITS-1:0]  g_raw;
    logic [COLOR_BITS-1:0]  r_raw;
    logic [COLOR_BITS-1:0]  b_raw;
    logic [WORD_BITS-1:0]   word;
    logic                   tx_ready;

    // (c8 * (bright + 1)) >> 8: full brightness is transparent, zero blanks the channel.
    function automatic logic [7:0] scale(input logic [7:0] c8, input logic [7:0] br);
        logic [15:0] prod;
        prod = 16'(c8) * 16'({1'b0, br} + 9'd1);
        return prod[15:8];
    endfunction

    always_comb begin
        g_raw = COLOR_BITS'(green >> (int'(idx) * COLOR_BITS));
        r_raw = COLOR_BITS'(red   >> (int'(idx) * COLOR_BITS));
        b_raw = COLOR_BITS'(blue  >> (int'(idx) * COLOR_BITS));
        word  = {scale(expand_color(8'(g_raw), COLOR_BITS), bright),
                 scale(expand_color(8'(r_raw), COLOR_BITS), bright),
                 scale(expand_color(8'(b_raw), COLOR_BITS), bright)};
    end

    wled_bit_tx #(
        .C0H  (C0H),
        .C1H  (C1H),
        .CBIT (CBIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == LOAD),
        .word  (word),
        .wled  (wled),
        .ready (tx_ready)
    );

    // frame_done is raised one cycle early so the registered pulse lands on the last latch cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            rst_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (AUTO_REFRESH != 0 || start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: state <= BIT;
                BIT: begin
                    if (tx_ready) begin
                        rst_cnt <= '0;
                        if (idx < 8'(NUM_LEDS - 1)) begin
                            idx   <= idx + 8'd1;
                            state <= LOAD;
                        end else begin
                            state <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (rst_cnt == RW'(CRST - 2)) frame_done <= 1'b1;
                    if (rst_cnt == RW'(CRST - 1)) begin
                        rst_cnt <= '0;
                        idx     <= '0;
                        if (AUTO_REFRESH != 0) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dout_wled_rgb.sv
// Self-checking bench: a manual-start two-LED 3-bit chain and an auto-refresh
// single-LED 1-bit chain, decoded from wled pulse widths against a colour model.
module tb_dout_wled_rgb;

    // Cycle counts at 27 MHz: 400 ns, 800 ns, 1250 ns, 300 us.
    localparam int T0 = 10;
    localparam int T1 = 21;
    localparam int TB = 33;
    localparam int TR = 8100;

    localparam int NL_M = 2;
    localparam int CB_M = 3;
    localparam int NL_A = 1;
    localparam int CB_A = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n_m, rst_n_a, start_m, start_a;
    logic [NL_M*CB_M-1:0]   green_m, red_m, blue_m;
    logic [NL_A*CB_A-1:0]   green_a, red_a, blue_a;
    logic [7:0]             bright_m, bright_a;
    logic                   wled_m, busy_m, done_m;
    logic                   wled_a, busy_a, done_a;

    logic mon_sel;
    logic mon_wled, mon_done;
    assign mon_wled = mon_sel ? wled_a : wled_m;
    assign mon_done = mon_sel ? done_a : done_m;

    dout_wled_rgb #(
        .CLK_MHZ(27), .NUM_LEDS(NL_M), .COLOR_BITS(CB_M), .AUTO_REFRESH(0),
        .T0H_NS(400), .T1H_NS(800), .TBIT_NS(1250), .RESET_US(300)
    ) u_man (
        .clk(clk), .rst_n(rst_n_m), .green(green_m), .red(red_m), .blue(blue_m),
        .bright(bright_m), .start(start_m), .wled(wled_m), .busy(busy_m),
        .frame_done(done_m)
    );

    dout_wled_rgb #(
        .CLK_MHZ(27), .NUM_LEDS(NL_A), .COLOR_BITS(CB_A), .AUTO_REFRESH(1),
        .T0H_NS(400), .T1H_NS(800), .TBIT_NS(1250), .RESET_US(300)
    ) u_auto (
        .clk(clk), .rst_n(rst_n_a), .green(green_a), .red(red_a), .blue(blue_a),
        .bright(bright_a), .start(start_a), .wled(wled_a), .busy(busy_a),
        .frame_done(done_a)
    );

    int n_checks;
    int n_pass;
    int n_fail;

    int hiLen[48];
    int loLen[48];
    int latchLen;
    int latchHigh;
    int startInLatch;
    logic [23:0] expWords[2];

    // A B-bit value repeated forever is the binary fraction c/(2^B-1); its first 8 bits
    // are floor(256*c/(2^B-1)), with all-ones saturating to 255.
    function automatic int expand8(input int c, input int nb);
        int v;
        v = (256 * c) / ((1 << nb) - 1);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int scaleModel(input int c8, input int br);
        return (c8 * (br + 1)) / 256;
    endfunction

    function automatic logic [23:0] expWord(input int g, input int r, input int b,
                                            input int br, input int nb);
        int w;
        w = (scaleModel(expand8(g, nb), br) << 16) |
            (scaleModel(expand8(r, nb), br) << 8)  |
             scaleModel(expand8(b, nb), br);
        return 24'(w);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int g0, input int r0, input int b0,
                                 input int g1, input int r1, input int b1, input int br);
        green_m     = {3'(g1), 3'(g0)};
        red_m       = {3'(r1), 3'(r0)};
        blue_m      = {3'(b1), 3'(b0)};
        bright_m    = 8'(br);
        expWords[0] = expWord(g0, r0, b0, br, CB_M);
        expWords[1] = expWord(g1, r1, b1, br, CB_M);
    endtask

    // Start is sampled at the first posedge, LOAD follows, and wled rises one cycle later.
    task automatic startFrame();
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        checkOutput("m_loadBusy", busy_m, 1);
        checkOutput("m_loadWledLow", wled_m, 0);
        @(negedge clk);
        checkOutput("m_firstRise", wled_m, 1);
    endtask

    // Measures high/low cycles of each bit, then the low stretch up to frame_done.
    task automatic captureFrame(input int nbits);
        int n;
        n = 0;
        while (mon_wled !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frameStartSeen", mon_wled, 1);
        for (int b = 0; b < nbits; b++) begin
            hiLen[b] = 0;
            loLen[b] = 0;
            while (mon_wled === 1'b1 && hiLen[b] < 100) begin
                @(negedge clk);
                hiLen[b]++;
            end
            if (b < nbits - 1) begin
                while (mon_wled !== 1'b1 && loLen[b] < 100) begin
                    @(negedge clk);
                    loLen[b]++;
                end
            end
        end
        latchLen  = 1;
        latchHigh = 0;
        while (mon_done !== 1'b1 && latchLen < 9000) begin
            start_m = (startInLatch != 0 && latchLen == startInLatch);
            @(negedge clk);
            latchLen++;
            if (mon_wled !== 1'b0) latchHigh++;
        end
        start_m = 1'b0;
    endtask

    task automatic checkFrame(input int nleds);
        int nb, th, led, pos;
        nb = nleds * 24;
        for (int b = 0; b < nb; b++) begin
            led = b / 24;
            pos = 23 - (b % 24);
            th  = (((expWords[led] >> pos) & 24'd1) != 0) ? T1 : T0;
            checkOutput($sformatf("led%0d_bit%0d_high", led, pos), hiLen[b], th);
            if (b < nb - 1)
                checkOutput($sformatf("led%0d_bit%0d_period", led, pos),
                            hiLen[b] + loLen[b], (pos == 0) ? TB + 1 : TB);
            else
                checkOutput("lastBitLowPlusLatch", latchLen, (TB - th) + TR);
        end
        checkOutput("latchWledLow", latchHigh, 0);
    endtask

    function automatic int decodeByte(input int first);
        int v;
        v = 0;
        for (int k = 0; k < 8; k++) v = (v << 1) | ((hiLen[first + k] == T1) ? 1 : 0);
        return v;
    endfunction

    // After frame_done a manual chain must drop busy and keep the pin low.
    task automatic endFrameManual(input string tag);
        int bad;
        checkOutput({tag, "_busyAtDone"}, busy_m, 1);
        @(negedge clk);
        checkOutput({tag, "_doneOneCycle"}, done_m, 0);
        checkOutput({tag, "_busyCleared"}, busy_m, 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (wled_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
        end
        checkOutput({tag, "_quietAfter"}, bad, 0);
    endtask

    initial begin
        int bad, ones;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        startInLatch = 0;
        mon_sel  = 1'b0;
        rst_n_m  = 1'b0;
        rst_n_a  = 1'b0;
        start_m  = 1'b0;
        start_a  = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        green_a  = '0;
        red_a    = '0;
        blue_a   = '0;
        bright_a = '0;

        repeat (3) @(negedge clk);
        checkOutput("m_resetWled", wled_m, 0);
        checkOutput("m_resetBusy", busy_m, 0);
        checkOutput("m_resetDone", done_m, 0);
        checkOutput("a_resetWled", wled_a, 0);
        checkOutput("a_resetBusy", busy_a, 0);

        rst_n_m = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (wled_m !== 1'b0 || busy_m !== 1'b0) bad++;
        end
        checkOutput("m_idleWithoutStart", bad, 0);

        // LED1 red = 3'b101 at bright 127 must come out as 0x5B.
        applyStimulus($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), 5, $urandom_range(0, 7), 127);
        startFrame();
        captureFrame(48);
        checkFrame(2);
        checkOutput("m_led1RedByte", decodeByte(32), 8'h5B);
        endFrameManual("frameA");

        // Zero brightness blanks everything; a start inside the latch must be dropped.
        applyStimulus(7, 7, 7, 7, 7, 7, 0);
        startFrame();
        startInLatch = 4000;
        captureFrame(48);
        startInLatch = 0;
        checkFrame(2);
        ones = 0;
        for (int b = 0; b < 48; b++) if (hiLen[b] != T0) ones++;
        checkOutput("m_bright0AllZeroBits", ones, 0);
        endFrameManual("frameB");

        applyStimulus($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 255));
        startFrame();
        captureFrame(48);
        checkFrame(2);
        endFrameManual("frameC");

        // Auto-refresh chain: green=1, red=0, blue=0 at full brightness.
        mon_sel     = 1'b1;
        green_a     = 1'b1;
        red_a       = 1'b0;
        blue_a      = 1'b0;
        bright_a    = 8'd255;
        expWords[0] = expWord(1, 0, 0, 255, CB_A);
        @(negedge clk);
        rst_n_a = 1'b1;
        @(negedge clk);
        checkOutput("a_loadBusy", busy_a, 1);
        checkOutput("a_loadWledLow", wled_a, 0);
        @(negedge clk);
        checkOutput("a_firstRise", wled_a, 1);
        captureFrame(24);
        checkFrame(1);
        checkOutput("a_greenByte", decodeByte(0), 8'hFF);
        checkOutput("a_busyAtDone", busy_a, 1);
        @(negedge clk);
        checkOutput("a_doneOneCycle", done_a, 0);
        checkOutput("a_busyHeldForRefresh", busy_a, 1);
        checkOutput("a_reloadWledLow", wled_a, 0);
        @(negedge clk);
        checkOutput("a_autoRestartRise", wled_a, 1);

        // Reset mid-bit while the pin is high must clear it without a clock edge.
        repeat (5) @(negedge clk);
        checkOutput("a_preResetHigh", wled_a, 1);
        green_a     = 1'($urandom_range(0, 1));
        red_a       = 1'($urandom_range(0, 1));
        blue_a      = 1'($urandom_range(0, 1));
        bright_a    = 8'($urandom_range(0, 255));
        expWords[0] = expWord(int'(green_a), int'(red_a), int'(blue_a), int'(bright_a), CB_A);
        #2;
        rst_n_a = 1'b0;
        #1;
        checkOutput("a_asyncResetWled", wled_a, 0);
        checkOutput("a_asyncResetBusy", busy_a, 0);
        @(negedge clk);
        rst_n_a = 1'b1;
        @(negedge clk);
        checkOutput("a_postResetLoadBusy", busy_a, 1);
        checkOutput("a_postResetWledLow", wled_a, 0);
        @(negedge clk);
        checkOutput("a_postResetRise", wled_a, 1);
        captureFrame(24);
        checkFrame(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
